mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATABITS, default 32, data word width; ADDRBITS, default 32, address width.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 d_addr  input  ADDRBITS  dcache request/beat address.
REQ-005 d_in  input  DATABITS  dcache write beat data.
REQ-006 d_rdreq  input  1  dcache read burst request, held until accepted.
REQ-007 d_wrreq  input  1  dcache write request/beat valid.
REQ-008 d_ack  output  1  dcache beat accepted this cycle.
REQ-009 d_out  output  DATABITS  read data to dcache.
REQ-010 d_out_valid  output  1  d_out valid.
REQ-011 i_addr  input  ADDRBITS  icache read burst address.
REQ-012 i_rdreq  input  1  icache read burst request, held until accepted.
REQ-013 i_ack  output  1  icache request accepted this cycle.
REQ-014 i_out  output  DATABITS  read data to icache.
REQ-015 i_out_valid  output  1  i_out valid.
REQ-016 mem_addr  output  ADDRBITS  registered address to memory controller.
REQ-017 mem_in  output  DATABITS  registered write data.
REQ-018 mem_rdreq  output  1  one-cycle read burst start pulse.
REQ-019 mem_wrreq  output  1  one-cycle write beat pulse.
REQ-020 mem_out  input  DATABITS  read data from memory.
REQ-021 mem_out_valid  input  1  mem_out valid.
REQ-022 mem_burstlen  input  16  beats per burst.

Function
REQ-023 States SHALL be IDLE, READ, WRITE; owner register SHALL record the granted port (D or I).
REQ-024 A beat SHALL transfer in a cycle where the port's request and its ack are both 1.
REQ-025 IDLE: ack SHALL be combinational, 1 only to the winner among requesting ports; READ: both acks 0; WRITE: d_ack=1 when owner=D, i_ack=0.
REQ-026 Winner SHALL be round-robin: single requester wins; if both, port other than last_owner wins; last_owner updated on each IDLE transfer.
REQ-027 d_wrreq and d_rdreq both high SHALL be treated as write.
REQ-028 On IDLE transfer: latch owner, type, burst length (mem_burstlen, 0 treated as 1) and set beat counter to 1; next state READ or WRITE, except write with burst length 1 returns to IDLE.
REQ-029 Every transfer SHALL register port addr/data into mem_addr/mem_in and pulse mem_rdreq (read) or mem_wrreq (write) high for exactly one cycle, the cycle after the transfer (latency 1).
REQ-030 mem_addr/mem_in SHALL hold last value when no transfer occurs; mem_rdreq/mem_wrreq SHALL be 0 otherwise.
REQ-031 WRITE: each transfer increments beat counter; transfer completing the latched length SHALL return to IDLE; d_wrreq low cycles are bubbles, no state change.
REQ-032 READ: owner's out_valid SHALL equal mem_out_valid and out SHALL equal mem_out combinationally; each valid beat increments counter; beat reaching latched length SHALL return to IDLE.
REQ-033 Non-owner out_valid SHALL be 0 with out 0; mem_out_valid in IDLE or WRITE SHALL be ignored.
REQ-034 Re-grant SHALL not occur in the cycle a burst completes; earliest next IDLE transfer is the following cycle.
REQ-035 Beat counter SHALL be 16 bits, no wrap within a burst (max 65535 beats).

Reset
REQ-036 reset_n low SHALL force IDLE, owner=D, last_owner=I (dcache first priority), counter 0, mem_addr/mem_in 0, mem_rdreq/mem_wrreq 0, acks 0, out_valid 0, outs 0.
REQ-037 Reset mid-burst SHALL abandon the burst; beats arriving after release SHALL be ignored in IDLE.

Verification
REQ-038 Simultaneous d_rdreq/i_rdreq from reset, burstlen 4 -> d_ack cycle 0, mem_rdreq pulse cycle 1 with d_addr, 4 mem_out_valid beats to d_out only, then i_ack next IDLE cycle.
REQ-039 Dcache write burstlen 4, d_wrreq with one bubble -> 4 mem_wrreq pulses with matching addr/data each one cycle after transfer, return to IDLE after 4th.
REQ-040 Both ports requesting continuously, burstlen 2 -> grants alternate D,I,D,I; no out_valid leaks to non-owner.
REQ-041 mem_burstlen=0 read -> treated as 1; IDLE after first mem_out_valid.
REQ-042 reset_n low after 2 of 8 read beats -> all outputs reset values; later mem_out_valid gives no out_valid.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates dcache and icache memory traffic onto a single
// memory controller port. Grants are round-robin, made only in IDLE; a grant
// starts either a read burst (beats returned from memory) or a dcache write
// burst (beats pushed by the dcache, with bubbles allowed). Every accepted beat
// is forwarded to memory as registered address/data plus a one-cycle pulse.
module mem_arbiter #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    // dcache port
    input  logic [ADDRBITS-1:0] d_addr,
    input  logic [DATABITS-1:0] d_in,
    input  logic                d_rdreq,
    input  logic                d_wrreq,
    output logic                d_ack,
    output logic [DATABITS-1:0] d_out,
    output logic                d_out_valid,
    // icache port
    input  logic [ADDRBITS-1:0] i_addr,
    input  logic                i_rdreq,
    output logic                i_ack,
    output logic [DATABITS-1:0] i_out,
    output logic                i_out_valid,
    // memory controller port
    output logic [ADDRBITS-1:0] mem_addr,
    output logic [DATABITS-1:0] mem_in,
    output logic                mem_rdreq,
    output logic                mem_wrreq,
    input  logic [DATABITS-1:0] mem_out,
    input  logic                mem_out_valid,
    input  logic [15:0]         mem_burstlen
);

    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Round-robin pick: a lone requester wins; on contention the port that
    // did not win last time gets the grant.
    function automatic logic pick_winner(input logic d_req, input logic i_req,
                                         input logic last_owner);
        logic win;
        if (d_req && i_req) begin
            win = ~last_owner;
        end else if (i_req) begin
            win = OWNER_I;
        end else begin
            win = OWNER_D;
        end
        return win;
    endfunction

    state_t              state_r, state_next_s;
    logic                owner_r, owner_next_s;
    logic                last_owner_r, last_owner_next_s;
    logic [15:0]         burst_len_r, burst_len_next_s;
    logic [15:0]         beat_cnt_r, beat_cnt_next_s;
    logic [ADDRBITS-1:0] mem_addr_r, mem_addr_next_s;
    logic [DATABITS-1:0] mem_in_r, mem_in_next_s;
    logic                mem_rdreq_r, mem_rdreq_next_s;
    logic                mem_wrreq_r, mem_wrreq_next_s;

    logic                d_req_s;
    logic                i_req_s;
    logic                any_req_s;
    logic                winner_s;
    logic                d_ack_s;
    logic                i_ack_s;
    logic [15:0]         req_len_s;
    logic                grant_write_s;
    logic [15:0]         beat_inc_s;
    logic [DATABITS-1:0] d_out_s;
    logic [DATABITS-1:0] i_out_s;
    logic                d_out_valid_s;
    logic                i_out_valid_s;

    // Request decode, winner selection and combinational acknowledge.
    always_comb begin
        d_req_s   = d_rdreq | d_wrreq;
        i_req_s   = i_rdreq;
        any_req_s = d_req_s | i_req_s;
        winner_s  = pick_winner(d_req_s, i_req_s, last_owner_r);
        // A zero burst length is promoted to a single beat.
        req_len_s     = (mem_burstlen == 16'd0) ? 16'd1 : mem_burstlen;
        // Simultaneous read and write from the dcache counts as a write.
        grant_write_s = (winner_s == OWNER_D) & d_wrreq;
        beat_inc_s    = beat_cnt_r + 16'd1;
        d_ack_s       = 1'b0;
        i_ack_s       = 1'b0;
        if (reset_n) begin
            case (state_r)
                ST_IDLE: begin
                    d_ack_s = d_req_s & (winner_s == OWNER_D);
                    i_ack_s = i_req_s & (winner_s == OWNER_I);
                end
                ST_READ: begin
                    d_ack_s = 1'b0;
                    i_ack_s = 1'b0;
                end
                ST_WRITE: begin
                    d_ack_s = (owner_r == OWNER_D);
                    i_ack_s = 1'b0;
                end
                default: begin
                    d_ack_s = 1'b0;
                    i_ack_s = 1'b0;
                end
            endcase
        end else begin
            d_ack_s = 1'b0;
            i_ack_s = 1'b0;
        end
    end

    // Steer returning read data to the burst owner only; others see zero.
    always_comb begin
        d_out_s       = '0;
        i_out_s       = '0;
        d_out_valid_s = 1'b0;
        i_out_valid_s = 1'b0;
        if (state_r == ST_READ) begin
            if (owner_r == OWNER_D) begin
                d_out_s       = mem_out;
                d_out_valid_s = mem_out_valid;
            end else begin
                i_out_s       = mem_out;
                i_out_valid_s = mem_out_valid;
            end
        end else begin
            d_out_s       = '0;
            i_out_s       = '0;
            d_out_valid_s = 1'b0;
            i_out_valid_s = 1'b0;
        end
    end

    // Next-state, burst bookkeeping and memory-side register updates.
    always_comb begin
        state_next_s      = state_r;
        owner_next_s      = owner_r;
        last_owner_next_s = last_owner_r;
        burst_len_next_s  = burst_len_r;
        beat_cnt_next_s   = beat_cnt_r;
        mem_addr_next_s   = mem_addr_r;
        mem_in_next_s     = mem_in_r;
        mem_rdreq_next_s  = 1'b0;
        mem_wrreq_next_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    owner_next_s      = winner_s;
                    last_owner_next_s = winner_s;
                    burst_len_next_s  = req_len_s;
                    beat_cnt_next_s   = 16'd1;
                    if (winner_s == OWNER_D) begin
                        mem_addr_next_s = d_addr;
                        mem_in_next_s   = d_in;
                    end else begin
                        mem_addr_next_s = i_addr;
                    end
                    if (grant_write_s) begin
                        mem_wrreq_next_s = 1'b1;
                        // A single-beat write is finished by the grant itself.
                        state_next_s = (req_len_s == 16'd1) ? ST_IDLE : ST_WRITE;
                    end else begin
                        mem_rdreq_next_s = 1'b1;
                        state_next_s     = ST_READ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                // beat_cnt_r is the 1-based index of the beat being awaited.
                if (mem_out_valid) begin
                    if (beat_cnt_r == burst_len_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        beat_cnt_next_s = beat_inc_s;
                    end
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_WRITE: begin
                // beat_cnt_r counts beats already sent; low d_wrreq is a bubble.
                if (d_wrreq && (owner_r == OWNER_D)) begin
                    beat_cnt_next_s  = beat_inc_s;
                    mem_addr_next_s  = d_addr;
                    mem_in_next_s    = d_in;
                    mem_wrreq_next_s = 1'b1;
                    if (beat_inc_s == burst_len_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_WRITE;
                    end
                end else begin
                    state_next_s = ST_WRITE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and memory-side registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_D;
            last_owner_r <= OWNER_I;
            burst_len_r  <= 16'd0;
            beat_cnt_r   <= 16'd0;
            mem_addr_r   <= '0;
            mem_in_r     <= '0;
            mem_rdreq_r  <= 1'b0;
            mem_wrreq_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            owner_r      <= owner_next_s;
            last_owner_r <= last_owner_next_s;
            burst_len_r  <= burst_len_next_s;
            beat_cnt_r   <= beat_cnt_next_s;
            mem_addr_r   <= mem_addr_next_s;
            mem_in_r     <= mem_in_next_s;
            mem_rdreq_r  <= mem_rdreq_next_s;
            mem_wrreq_r  <= mem_wrreq_next_s;
        end
    end

    assign d_ack       = d_ack_s;
    assign i_ack       = i_ack_s;
    assign d_out       = d_out_s;
    assign i_out       = i_out_s;
    assign d_out_valid = d_out_valid_s;
    assign i_out_valid = i_out_valid_s;
    assign mem_addr    = mem_addr_r;
    assign mem_in      = mem_in_r;
    assign mem_rdreq   = mem_rdreq_r;
    assign mem_wrreq   = mem_wrreq_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// all compared each cycle against a transaction-level model that tracks the
// current burst as "who owns it, what kind, how many beats are still due".
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] d_addr, d_in, i_addr, mem_out;
    logic        d_rdreq, d_wrreq, i_rdreq, mem_out_valid;
    logic [15:0] mem_burstlen;
    logic        d_ack, i_ack, d_out_valid, i_out_valid, mem_rdreq, mem_wrreq;
    logic [31:0] d_out, i_out, mem_addr, mem_in;

    always #5 clk = ~clk;

    mem_arbiter #(.DATABITS(32), .ADDRBITS(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .d_addr(d_addr), .d_in(d_in), .d_rdreq(d_rdreq), .d_wrreq(d_wrreq),
        .d_ack(d_ack), .d_out(d_out), .d_out_valid(d_out_valid),
        .i_addr(i_addr), .i_rdreq(i_rdreq), .i_ack(i_ack), .i_out(i_out),
        .i_out_valid(i_out_valid),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_rdreq(mem_rdreq),
        .mem_wrreq(mem_wrreq), .mem_out(mem_out), .mem_out_valid(mem_out_valid),
        .mem_burstlen(mem_burstlen)
    );

    int checks = 0;
    int errors = 0;

    // Model: busy kind (0 none, 1 read, 2 write), owner/last (0 = D, 1 = I),
    // beats still due, and the values the memory-side registers must hold.
    int          m_kind;
    bit          m_owner, m_last;
    int          m_left;
    logic [31:0] m_addr, m_in;
    bit          m_rd, m_wr;

    // Samples of the DUT taken during the last cycle, for directed checks.
    bit          s_dack, s_iack, s_dov, s_iov, s_mrd, s_mwr;
    logic [31:0] s_maddr;
    int          gq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_kind  = 0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_left  = 0;
        m_addr  = 32'd0;
        m_in    = 32'd0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
    endtask

    // One clock: inputs already applied; compare at falling edge, advance model.
    task automatic cyc();
        bit          dreq, ireq, win, e_dack, e_iack, e_dov, e_iov, wr;
        logic [31:0] e_dout, e_iout;
        int          len;
        @(negedge clk);
        if (!reset_n) model_reset();
        dreq = d_rdreq | d_wrreq;
        ireq = i_rdreq;
        win  = (dreq && ireq) ? !m_last : ireq;
        e_dack = 1'b0; e_iack = 1'b0; e_dov = 1'b0; e_iov = 1'b0;
        e_dout = 32'd0; e_iout = 32'd0;
        if (reset_n) begin
            if (m_kind == 0) begin
                e_dack = dreq && !win;
                e_iack = ireq && win;
            end else if (m_kind == 2) begin
                e_dack = 1'b1;
            end else if (m_owner == 1'b0) begin
                e_dov  = mem_out_valid;
                e_dout = mem_out;
            end else begin
                e_iov  = mem_out_valid;
                e_iout = mem_out;
            end
        end
        chk("d_ack", 64'(d_ack), 64'(e_dack));
        chk("i_ack", 64'(i_ack), 64'(e_iack));
        chk("d_out_valid", 64'(d_out_valid), 64'(e_dov));
        chk("i_out_valid", 64'(i_out_valid), 64'(e_iov));
        chk("d_out", 64'(d_out), 64'(e_dout));
        chk("i_out", 64'(i_out), 64'(e_iout));
        chk("mem_rdreq", 64'(mem_rdreq), 64'(m_rd));
        chk("mem_wrreq", 64'(mem_wrreq), 64'(m_wr));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (m_wr || !reset_n) chk("mem_in", 64'(mem_in), 64'(m_in));
        s_dack = d_ack; s_iack = i_ack; s_dov = d_out_valid; s_iov = i_out_valid;
        s_mrd = mem_rdreq; s_mwr = mem_wrreq; s_maddr = mem_addr;
        if (d_ack) gq.push_back(0);
        else if (i_ack) gq.push_back(1);
        if (reset_n) begin
            m_rd = 1'b0;
            m_wr = 1'b0;
            if (m_kind == 0) begin
                if (dreq || ireq) begin
                    m_owner = win;
                    m_last  = win;
                    len     = (mem_burstlen == 16'd0) ? 1 : int'(mem_burstlen);
                    wr      = !win && d_wrreq;
                    m_addr  = win ? i_addr : d_addr;
                    if (!win) m_in = d_in;
                    if (wr) begin
                        m_wr   = 1'b1;
                        m_left = len - 1;
                        m_kind = (m_left == 0) ? 0 : 2;
                    end else begin
                        m_rd   = 1'b1;
                        m_left = len;
                        m_kind = 1;
                    end
                end
            end else if (m_kind == 1) begin
                if (mem_out_valid) begin
                    m_left--;
                    if (m_left == 0) m_kind = 0;
                end
            end else begin
                if (d_wrreq) begin
                    m_addr = d_addr;
                    m_in   = d_in;
                    m_wr   = 1'b1;
                    m_left--;
                    if (m_left == 0) m_kind = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        d_rdreq = 1'b0; d_wrreq = 1'b0; i_rdreq = 1'b0; mem_out_valid = 1'b0;
    endtask

    int nb, nov;

    initial begin
        reset_n = 1'b0;
        d_addr = 32'd0; d_in = 32'd0; i_addr = 32'd0; mem_out = 32'd0;
        mem_burstlen = 16'd4;
        idle_inputs();
        model_reset();
        #1;
        cyc();
        cyc();
        reset_n = 1'b1;

        // Contention from reset: dcache first, 4 beats to dcache, then icache.
        d_addr = 32'h1000_0040; i_addr = 32'h2000_0080; mem_burstlen = 16'd4;
        d_rdreq = 1'b1; i_rdreq = 1'b1;
        cyc();
        chk("r38_d_ack", 64'(s_dack), 64'd1);
        chk("r38_i_ack", 64'(s_iack), 64'd0);
        d_rdreq = 1'b0;
        cyc();
        chk("r38_rdpulse", 64'(s_mrd), 64'd1);
        chk("r38_addr", 64'(s_maddr), 64'h1000_0040);
        nb = 0; nov = 0;
        for (int k = 0; k < 4; k++) begin
            mem_out_valid = 1'b1; mem_out = $urandom;
            cyc();
            nb += int'(s_dov); nov += int'(s_iov);
        end
        mem_out_valid = 1'b0;
        chk("r38_dbeats", 64'(nb), 64'd4);
        chk("r38_ileak", 64'(nov), 64'd0);
        cyc();
        chk("r38_i_ack_after", 64'(s_iack), 64'd1);
        i_rdreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_out_valid = 1'b1; mem_out = $urandom;
            cyc();
        end
        idle_inputs();
        cyc();

        // Dcache write burst of 4 with one bubble.
        mem_burstlen = 16'd4; nb = 0;
        for (int k = 0; k < 5; k++) begin
            d_wrreq = (k != 2);
            d_addr  = 32'h3000_0000 + 32'(k * 4);
            d_in    = $urandom;
            cyc();
            nb += int'(s_mwr);
        end
        d_wrreq = 1'b0; i_rdreq = 1'b1;
        cyc();
        nb += int'(s_mwr);
        chk("r39_pulses", 64'(nb), 64'd4);
        chk("r39_idle_i_ack", 64'(s_iack), 64'd1);
        i_rdreq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_out_valid = 1'b1; mem_out = $urandom;
            cyc();
        end
        idle_inputs();
        cyc();

        // Continuous contention, 2-beat bursts: grants alternate.
        gq.delete();
        mem_burstlen = 16'd2; d_rdreq = 1'b1; i_rdreq = 1'b1; mem_out_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mem_out = $urandom;
            cyc();
        end
        idle_inputs();
        chk("r40_ngrants", 64'(gq.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < gq.size()) chk("r40_order", 64'(gq[k]), 64'(k % 2));
        end
        cyc();
        cyc();

        // Zero burst length behaves as one beat.
        mem_burstlen = 16'd0; i_rdreq = 1'b1;
        cyc();
        chk("r41_i_ack", 64'(s_iack), 64'd1);
        i_rdreq = 1'b0; mem_out_valid = 1'b1; mem_out = 32'hCAFE_F00D;
        cyc();
        chk("r41_iov", 64'(s_iov), 64'd1);
        mem_out_valid = 1'b0; d_rdreq = 1'b1;
        cyc();
        chk("r41_next_d_ack", 64'(s_dack), 64'd1);
        d_rdreq = 1'b0; mem_out_valid = 1'b1;
        cyc();
        idle_inputs();
        cyc();

        // Reset after 2 of 8 beats abandons the burst.
        mem_burstlen = 16'd8; d_rdreq = 1'b1;
        cyc();
        d_rdreq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_out_valid = 1'b1; mem_out = $urandom;
            cyc();
        end
        reset_n = 1'b0;
        cyc();
        chk("r42_rst_dov", 64'(s_dov), 64'd0);
        chk("r42_rst_maddr", 64'(s_maddr), 64'd0);
        reset_n = 1'b1; nov = 0;
        for (int k = 0; k < 3; k++) begin
            mem_out_valid = 1'b1; mem_out = $urandom;
            cyc();
            nov += int'(s_dov) + int'(s_iov);
        end
        chk("r42_no_valid_after", 64'(nov), 64'd0);
        idle_inputs();
        cyc();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            reset_n       = ($urandom_range(0, 199) != 0);
            d_rdreq       = ($urandom_range(0, 9) < 4);
            d_wrreq       = ($urandom_range(0, 9) < 4);
            i_rdreq       = ($urandom_range(0, 9) < 4);
            mem_out_valid = ($urandom_range(0, 1) == 1);
            mem_burstlen  = 16'($urandom_range(0, 5));
            d_addr = $urandom; d_in = $urandom; i_addr = $urandom; mem_out = $urandom;
            cyc();
        end
        reset_n = 1'b1;
        idle_inputs();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
